// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: shared encodings for the E-stage multiply/divide unit.
//   md_op_e          : 4-bit MulDivOp encoding; codes 9..15 behave as MD_NONE.
//   MULT_CYCLES_DEF  : default busy cycles after the start cycle for mult/multu.
//   DIV_CYCLES_DEF   : default busy cycles after the start cycle for div/divu.
//   is_arith_op()    : true for the ops that launch a multi-cycle computation.
package mul_div_unit_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_arith_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: E-stage request and HI/LO result bundle of the multiply/divide unit.
//   req         : exception/interrupt taken this cycle, discards the E-stage op
//   MulDivOp    : E-stage op code (md_op_e encoding)
//   A, B        : rs / rt operands (already forwarded)
//   MulDiv_busy : start cycle or computation in flight
//   HI, LO      : architectural HI/LO registers
//   MulDiv_Out  : HI for MFHI, LO for MFLO, otherwise zero
// master = pipeline side driving the op, slave = mul_div_unit.
interface mul_div_unit_if;
  logic        req;
  logic [3:0]  MulDivOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        MulDiv_busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MulDiv_Out;

  modport master (
    output req, MulDivOp, A, B,
    input  MulDiv_busy, HI, LO, MulDiv_Out
  );

  modport slave (
    input  req, MulDivOp, A, B,
    output MulDiv_busy, HI, LO, MulDiv_Out
  );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: E-stage multiply/divide unit owning HI/LO.
//   clk   : system clock
//   reset : synchronous, active-high reset
//   md    : mul_div_unit_if.slave (req, MulDivOp, A, B in; MulDiv_busy, HI, LO, MulDiv_Out out)
// The result is computed in the start cycle and parked in pend_hi/pend_lo; a down-counter
// models the fixed latency and HI/LO are updated on the edge where the counter reaches zero.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic          clk,
  input logic          reset,
  mul_div_unit_if.slave md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0]  cnt;
  logic [31:0]       hi_r;
  logic [31:0]       lo_r;
  logic [31:0]       pend_hi;
  logic [31:0]       pend_lo;
  logic              pend_wr;

  logic              idle;
  logic              start;
  logic              is_div;
  logic              div_zero;
  logic              sovf;
  logic [CNT_W-1:0]  cnt_load;
  logic [63:0]       prod_s;
  logic [63:0]       prod_u;
  logic signed [31:0] sdivisor;
  logic [31:0]       udivisor;
  logic signed [31:0] squot;
  logic signed [31:0] srem;
  logic [31:0]       res_hi;
  logic [31:0]       res_lo;

  // Op decode and start qualification.
  always_comb begin
    idle     = (cnt == {CNT_W{1'b0}});
    start    = ~md.req & idle & is_arith_op(md.MulDivOp);
    is_div   = (md.MulDivOp == MD_DIV) || (md.MulDivOp == MD_DIVU);
    cnt_load = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
  end

  // Result datapath. The divisor is forced to 1 for B==0 (result discarded) and for
  // 0x8000_0000 / -1, where A/1 already yields the required quotient 0x8000_0000 and
  // remainder 0 without ever performing the overflowing division.
  always_comb begin
    prod_s   = {{32{md.A[31]}}, md.A} * {{32{md.B[31]}}, md.B};
    prod_u   = {32'd0, md.A} * {32'd0, md.B};
    div_zero = (md.B == 32'd0);
    sovf     = (md.A == 32'h8000_0000) && (md.B == 32'hFFFF_FFFF);
    sdivisor = (div_zero || sovf) ? 32'sd1 : $signed(md.B);
    udivisor = div_zero ? 32'd1 : md.B;
    squot    = $signed(md.A) / sdivisor;
    srem     = $signed(md.A) % sdivisor;
    res_hi   = 32'd0;
    res_lo   = 32'd0;
    case (md.MulDivOp)
      MD_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      MD_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      MD_DIV:   begin res_hi = srem;          res_lo = squot;        end
      MD_DIVU:  begin res_hi = md.A % udivisor; res_lo = md.A / udivisor; end
      default:  begin res_hi = 32'd0;         res_lo = 32'd0;        end
    endcase
  end

  // Latency counter, pending result and HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= {CNT_W{1'b0}};
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
    end else if (start) begin
      cnt     <= cnt_load;
      pend_hi <= res_hi;
      pend_lo <= res_lo;
      pend_wr <= ~(is_div & div_zero);
    end else if (!idle) begin
      // In-flight work belongs to an older instruction: req and new ops do not affect it.
      cnt <= cnt - CNT_W'(1);
      if ((cnt == CNT_W'(1)) && pend_wr) begin
        hi_r <= pend_hi;
        lo_r <= pend_lo;
      end
    end else if (!md.req && (md.MulDivOp == MD_MTHI)) begin
      hi_r <= md.A;
    end else if (!md.req && (md.MulDivOp == MD_MTLO)) begin
      lo_r <= md.A;
    end else begin
      cnt <= cnt;
    end
  end

  // Busy covers the start cycle plus every cycle the counter is non-zero; MFHI/MFLO read mux.
  always_comb begin
    md.MulDiv_busy = start | ~idle;
    md.HI          = hi_r;
    md.LO          = lo_r;
    case (md.MulDivOp)
      MD_MFHI: md.MulDiv_Out = hi_r;
      MD_MFLO: md.MulDiv_Out = lo_r;
      default: md.MulDiv_Out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: self-checking bench for mul_div_unit. Directed spec cases plus
// randomized ops checked against a longint arithmetic reference model of HI/LO.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mul_div_unit_if md();

  mul_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk  (clk),
    .reset(reset),
    .md   (md)
  );

  int          tests = 0;
  int          fails = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;
  bit          inflight = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // While a computation is in flight only NONE/MFHI/MFLO may be presented.
  always @(negedge clk) begin
    if (inflight) begin
      tests++;
      assert (md.MulDivOp == MD_NONE || md.MulDivOp == MD_MFHI || md.MulDivOp == MD_MFLO) else begin
        fails++;
        $error("FAIL protocol observed_op=%0d expected=none/mfhi/mflo", md.MulDivOp);
      end
    end
  end

  // Reference arithmetic: plain 64-bit integer math on the operands.
  function automatic void model_arith(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] nh, output logic [31:0] nl, output bit wr);
    longint          sa, sb, p, q, r;
    longint unsigned ua, ub, pu, qu, ru;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    nh = hi_m; nl = lo_m; wr = 1'b1;
    if (op == MD_MULT) begin
      p = sa * sb; nh = p[63:32]; nl = p[31:0];
    end else if (op == MD_MULTU) begin
      pu = ua * ub; nh = pu[63:32]; nl = pu[31:0];
    end else if (b == 32'd0) begin
      wr = 1'b0;
    end else if (op == MD_DIV) begin
      q = sa / sb; r = sa % sb; nh = r[31:0]; nl = q[31:0];
    end else begin
      qu = ua / ub; ru = ua % ub; nh = ru[31:0]; nl = qu[31:0];
    end
  endfunction

  // One E-stage op: checks busy profile, reads during flight and final HI/LO.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic r);
    bit          starts;
    int          n, nb;
    logic [31:0] nh, nl;
    bit          wr;
    starts = is_arith_op(op) && !r;
    n = (op == MD_DIV || op == MD_DIVU) ? DC : MC;
    md.MulDivOp = op; md.A = a; md.B = b; md.req = r;
    @(negedge clk);
    chk("busy_start", md.MulDiv_busy, starts);
    if (op == MD_MFHI) chk("mfhi_out", md.MulDiv_Out, hi_m);
    else if (op == MD_MFLO) chk("mflo_out", md.MulDiv_Out, lo_m);
    else chk("out_zero", md.MulDiv_Out, 64'd0);
    if (starts) begin
      model_arith(op, a, b, nh, nl, wr);
      tick();
      md.MulDivOp = MD_MFHI; md.A = $urandom; md.req = 1'($urandom_range(0, 1));
      inflight = 1'b1;
      nb = 1;
      while (nb < 4 * DC) begin
        @(negedge clk);
        if (!md.MulDiv_busy) break;
        chk("inflight_hilo", {md.HI, md.LO}, {hi_m, lo_m});
        nb++;
        tick();
      end
      inflight = 1'b0;
      chk("busy_len", 64'(nb), 64'(n + 1));
      if (wr) begin hi_m = nh; lo_m = nl; end
      chk("done_hi", md.HI, hi_m);
      chk("done_lo", md.LO, lo_m);
      chk("done_mfhi", md.MulDiv_Out, hi_m);
      tick();
      md.MulDivOp = MD_NONE; md.req = 1'b0;
    end else begin
      if (!r && op == MD_MTHI) hi_m = a;
      if (!r && op == MD_MTLO) lo_m = a;
      tick();
      md.MulDivOp = MD_NONE; md.req = 1'b0;
      @(negedge clk);
      chk("idle_busy", md.MulDiv_busy, 64'd0);
      chk("idle_hi", md.HI, hi_m);
      chk("idle_lo", md.LO, lo_m);
      tick();
    end
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    logic        rr;
    md.req = 1'b0; md.MulDivOp = MD_NONE; md.A = 32'd0; md.B = 32'd0;
    repeat (2) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", md.MulDiv_busy, 64'd0);
    chk("rst_hi", md.HI, 64'd0);
    chk("rst_lo", md.LO, 64'd0);
    chk("rst_out", md.MulDiv_Out, 64'd0);
    tick();

    run_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    chk("mult_hi", md.HI, 64'hFFFF_FFFF);
    chk("mult_lo", md.LO, 64'hFFFF_FFFA);
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    chk("multu_hi", md.HI, 64'h0000_0001);
    chk("multu_lo", md.LO, 64'hFFFF_FFFE);
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_lo", md.LO, 64'hFFFF_FFFD);
    chk("div_hi", md.HI, 64'hFFFF_FFFF);
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("divovf_lo", md.LO, 64'h8000_0000);
    chk("divovf_hi", md.HI, 64'd0);
    run_op(MD_MTHI, 32'h11, 32'd0, 1'b0);
    run_op(MD_MTLO, 32'h22, 32'd0, 1'b0);
    run_op(MD_DIVU, 32'd10, 32'd0, 1'b0);
    chk("div0_hi", md.HI, 64'h11);
    chk("div0_lo", md.LO, 64'h22);
    run_op(MD_MTLO, 32'h1234, 32'd0, 1'b1);
    chk("mtlo_req_lo", md.LO, 64'h22);
    run_op(MD_MULT, 32'd5, 32'd7, 1'b1);
    chk("mult_req_hi", md.HI, 64'h11);
    run_op(4'd12, 32'hAAAA_5555, 32'd9, 1'b0);
    run_op(MD_MFLO, 32'd0, 32'd0, 1'b0);
    run_op(MD_MFHI, 32'd0, 32'd0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      rop = 4'($urandom_range(1, 8));
      ra  = $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 1) == 1 ? $urandom : 32'($urandom_range(1, 300)));
      if ($urandom_range(0, 3) == 0) ra = 32'(0 - $urandom_range(0, 1000));
      rr  = ($urandom_range(0, 5) == 0);
      run_op(rop, ra, rb, rr);
    end

    // Reset three cycles into a multiply: no late writeback afterwards.
    run_op(MD_MTHI, 32'h0000_DEAD, 32'd0, 1'b0);
    run_op(MD_MTLO, 32'h0000_BEEF, 32'd0, 1'b0);
    md.MulDivOp = MD_MULT; md.A = 32'd3; md.B = 32'd4;
    @(negedge clk);
    chk("rstmid_start", md.MulDiv_busy, 64'd1);
    tick();
    md.MulDivOp = MD_NONE;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    hi_m = 32'd0; lo_m = 32'd0;
    @(negedge clk);
    chk("rstmid_busy", md.MulDiv_busy, 64'd0);
    chk("rstmid_hi", md.HI, 64'd0);
    chk("rstmid_lo", md.LO, 64'd0);
    md.MulDivOp = MD_MFHI;
    #1;
    chk("rstmid_mfhi", md.MulDiv_Out, 64'd0);
    repeat (8) tick();
    @(negedge clk);
    chk("rstmid_late_busy", md.MulDiv_busy, 64'd0);
    chk("rstmid_late_hilo", {md.HI, md.LO}, 64'd0);
    md.MulDivOp = MD_NONE;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
